skin_segm_bbox: RTL and testbench

Downstream stage of the HSV colour-space converter in the skin-colour segmentation pipeline. Takes the H/S/V pixel stream and its sync signals, classifies each active pixel as skin or not with per-channel window thresholds, and emits a delayed binary mask stream with aligned syncs. It also accumulates a per-frame bounding box and a skin-pixel count, which are published once per frame at the vsync boundary.

---
 rtl/skin_segm_bbox_pkg.sv | 26 ++
 rtl/skin_segm_bbox_if.sv | 40 ++++
 rtl/skin_bbox_acc.sv | 91 +++++++++
 rtl/skin_segm_bbox.sv | 134 +++++++++++++
 tb/tb_skin_segm_bbox.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/skin_segm_bbox_pkg.sv
// Shared definitions for the skin segmentation stage and the display overlay stage:
// FSM encoding, default thresholds and the unsigned window compare.
package skin_segm_bbox_pkg;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } fsm_state_t;

  localparam logic [7:0] H_MIN_DEF = 8'd0;
  localparam logic [7:0] H_MAX_DEF = 8'd25;
  localparam logic [7:0] S_MIN_DEF = 8'd40;
  localparam logic [7:0] S_MAX_DEF = 8'd170;
  localparam logic [7:0] V_MIN_DEF = 8'd60;

  localparam int unsigned XW_DEF = 11;
  localparam int unsigned YW_DEF = 11;
  localparam int unsigned CW_DEF = 21;

  // lo <= val <= hi as one offset compare; stays meaningful when lo is 0 or hi is 255
  function automatic logic in_window(input logic [7:0] val, input logic [7:0] lo,
                                     input logic [7:0] hi);
    return 8'(val - lo) <= 8'(hi - lo);
  endfunction

endpackage

// File: rtl/skin_segm_bbox_if.sv
// Pixel-in / mask-and-statistics-out bundle of the skin segmentation stage.
interface skin_segm_bbox_if
  import skin_segm_bbox_pkg::*;
#(
  parameter int unsigned XW = XW_DEF,
  parameter int unsigned YW = YW_DEF,
  parameter int unsigned CW = CW_DEF
) ();

  logic [7:0]    H;
  logic [7:0]    S;
  logic [7:0]    V;
  logic          in_hsync;
  logic          in_vsync;
  logic          in_de;
  logic [7:0]    mask;
  logic          out_hsync;
  logic          out_vsync;
  logic          out_de;
  logic [XW-1:0] x_min;
  logic [XW-1:0] x_max;
  logic [YW-1:0] y_min;
  logic [YW-1:0] y_max;
  logic [CW-1:0] skin_count;
  logic          found;
  logic          bbox_valid;

  modport master (
    output H, S, V, in_hsync, in_vsync, in_de,
    input  mask, out_hsync, out_vsync, out_de,
    input  x_min, x_max, y_min, y_max, skin_count, found, bbox_valid
  );

  modport slave (
    input  H, S, V, in_hsync, in_vsync, in_de,
    output mask, out_hsync, out_vsync, out_de,
    output x_min, x_max, y_min, y_max, skin_count, found, bbox_valid
  );

endinterface

// File: rtl/skin_bbox_acc.sv
// Running bounding box / skin count for the current frame and the published copy
// of the last complete frame.
module skin_bbox_acc #(
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 11,
  parameter int unsigned CW = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic          skin,
  input  logic          frame_edge,
  input  logic          publish,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] skin_count,
  output logic          found,
  output logic          bbox_valid
);

  logic [XW-1:0] rx_min, rx_max, bx_min, bx_max, nx_min, nx_max;
  logic [YW-1:0] ry_min, ry_max, by_min, by_max, ny_min, ny_max;
  logic [CW-1:0] rcount, bcount, ncount;

  // A skin pixel coincident with the frame edge seeds the freshly cleared values
  always_comb begin
    bx_min = frame_edge ? '1 : rx_min;
    bx_max = frame_edge ? '0 : rx_max;
    by_min = frame_edge ? '1 : ry_min;
    by_max = frame_edge ? '0 : ry_max;
    bcount = frame_edge ? '0 : rcount;
    nx_min = bx_min;
    nx_max = bx_max;
    ny_min = by_min;
    ny_max = by_max;
    ncount = bcount;
    if (skin) begin
      nx_min = (x < bx_min) ? x : bx_min;
      nx_max = (x > bx_max) ? x : bx_max;
      ny_min = (y < by_min) ? y : by_min;
      ny_max = (y > by_max) ? y : by_max;
      ncount = (bcount != '1) ? bcount + CW'(1) : bcount;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_min     <= '1;
      rx_max     <= '0;
      ry_min     <= '1;
      ry_max     <= '0;
      rcount     <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      skin_count <= '0;
      found      <= 1'b0;
      bbox_valid <= 1'b0;
    end else if (valid) begin
      rx_min     <= nx_min;
      rx_max     <= nx_max;
      ry_min     <= ny_min;
      ry_max     <= ny_max;
      rcount     <= ncount;
      bbox_valid <= publish;
      if (publish) begin
        if (rcount != '0) begin
          x_min      <= rx_min;
          x_max      <= rx_max;
          y_min      <= ry_min;
          y_max      <= ry_max;
          skin_count <= rcount;
          found      <= 1'b1;
        end else begin
          x_min      <= '0;
          x_max      <= '0;
          y_min      <= '0;
          y_max      <= '0;
          skin_count <= '0;
          found      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/skin_segm_bbox.sv
// Skin classifier on the HSV stream: two-stage mask pipeline with delayed syncs,
// x/y pixel counters and a frame FSM driving per-frame bounding box statistics.
module skin_segm_bbox
  import skin_segm_bbox_pkg::*;
#(
  parameter logic [7:0]  H_MIN = H_MIN_DEF,
  parameter logic [7:0]  H_MAX = H_MAX_DEF,
  parameter logic [7:0]  S_MIN = S_MIN_DEF,
  parameter logic [7:0]  S_MAX = S_MAX_DEF,
  parameter logic [7:0]  V_MIN = V_MIN_DEF,
  parameter int unsigned XW    = XW_DEF,
  parameter int unsigned YW    = YW_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  input logic              ce,
  skin_segm_bbox_if.slave  bus
);

  logic [XW-1:0] x_cnt, x1;
  logic [YW-1:0] y_cnt, y1;
  logic          h_ok1, s_ok1, v_ok1, de1, hs1, vs1;
  logic [7:0]    mask_q;
  logic          de2, hs2, vs2;
  logic          skin_c, frame_edge_c, acc_clr_c, acc_pub_c, acc_skin_c;
  fsm_state_t    state, state_next;

  // Stage 1 plus counters; stage-1 syncs double as the previous-sample edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_ok1 <= 1'b0;
      s_ok1 <= 1'b0;
      v_ok1 <= 1'b0;
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (ce) begin
      h_ok1 <= in_window(bus.H, H_MIN, H_MAX);
      s_ok1 <= in_window(bus.S, S_MIN, S_MAX);
      v_ok1 <= in_window(bus.V, V_MIN, 8'hFF);
      de1   <= bus.in_de;
      hs1   <= bus.in_hsync;
      vs1   <= bus.in_vsync;
      x1    <= x_cnt;
      y1    <= y_cnt;
      if (!bus.in_de)
        x_cnt <= '0;
      else if (x_cnt != '1)
        x_cnt <= x_cnt + XW'(1);
      if (bus.in_vsync && !vs1)
        y_cnt <= '0;
      else if (!bus.in_de && de1 && y_cnt != '1)
        y_cnt <= y_cnt + YW'(1);
    end
  end

  assign skin_c       = de1 & h_ok1 & s_ok1 & v_ok1;
  assign frame_edge_c = vs1 & ~vs2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= 8'h00;
      de2    <= 1'b0;
      hs2    <= 1'b0;
      vs2    <= 1'b0;
    end else if (ce) begin
      mask_q <= skin_c ? 8'hFF : 8'h00;
      de2    <= de1;
      hs2    <= hs1;
      vs2    <= vs1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= WAIT_FRAME;
    else if (ce)
      state <= state_next;
  end

  // No statistics until a full frame has been seen after reset
  always_comb begin
    state_next = state;
    acc_clr_c  = 1'b0;
    acc_pub_c  = 1'b0;
    acc_skin_c = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (frame_edge_c) begin
          acc_clr_c  = 1'b1;
          acc_skin_c = skin_c;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        acc_skin_c = skin_c;
        if (frame_edge_c) begin
          acc_clr_c = 1'b1;
          acc_pub_c = 1'b1;
        end
      end
      default: state_next = WAIT_FRAME;
    endcase
  end

  skin_bbox_acc #(.XW(XW), .YW(YW), .CW(CW)) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (ce),
    .skin       (acc_skin_c),
    .frame_edge (acc_clr_c),
    .publish    (acc_pub_c),
    .x          (x1),
    .y          (y1),
    .x_min      (bus.x_min),
    .x_max      (bus.x_max),
    .y_min      (bus.y_min),
    .y_max      (bus.y_max),
    .skin_count (bus.skin_count),
    .found      (bus.found),
    .bbox_valid (bus.bbox_valid)
  );

  assign bus.mask      = mask_q;
  assign bus.out_de    = de2;
  assign bus.out_hsync = hs2;
  assign bus.out_vsync = vs2;

endmodule

// File: tb/tb_skin_segm_bbox.sv
// Bench for skin_segm_bbox: frame-level reference model of classification, 2-sample
// latency and per-frame publish, compared every cycle against the DUT outputs.
module tb_skin_segm_bbox;

  localparam int H_LO = 0;
  localparam int H_HI = 25;
  localparam int S_LO = 40;
  localparam int S_HI = 170;
  localparam int V_LO = 60;

  typedef struct {
    int mask, de, hs, vs;
    int valid, xmin, xmax, ymin, ymax, cnt, found;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  bit   gated;

  skin_segm_bbox_if bus ();

  skin_segm_bbox dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t hist [0:16383];
  int   n;
  int   errors = 0;
  int   checks = 0;

  // Frame-level model state
  int   armed, prev_vs;
  int   ax_min, ax_max, ay_min, ay_max, acnt;
  exp_t pub;

  task automatic check_eq(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (sample %0d, t=%0t)", tag, obs, expv, n, $time);
    end
  endtask

  function automatic int is_skin(input int h, input int s, input int v, input int de);
    return (de != 0 && h >= H_LO && h <= H_HI && s >= S_LO && s <= S_HI && v >= V_LO) ? 1 : 0;
  endfunction

  task automatic model_reset();
    armed = 0;
    prev_vs = 0;
    acnt = 0;
    pub = '{default: 0};
  endtask

  task automatic model_push(input int h, input int s, input int v, input int hs,
                            input int vs, input int de, input int x, input int y);
    exp_t e;
    int sk;
    sk = is_skin(h, s, v, de);
    pub.valid = 0;
    if (vs != 0 && prev_vs == 0) begin
      if (armed != 0) begin
        pub.valid = 1;
        if (acnt > 0) begin
          pub.xmin = ax_min; pub.xmax = ax_max;
          pub.ymin = ay_min; pub.ymax = ay_max;
          pub.cnt = acnt;    pub.found = 1;
        end else begin
          pub.xmin = 0; pub.xmax = 0; pub.ymin = 0; pub.ymax = 0;
          pub.cnt = 0;  pub.found = 0;
        end
      end
      armed = 1;
      acnt = 0;
    end
    prev_vs = vs;
    if (sk != 0) begin
      if (acnt == 0) begin
        ax_min = x; ax_max = x; ay_min = y; ay_max = y;
      end else begin
        if (x < ax_min) ax_min = x;
        if (x > ax_max) ax_max = x;
        if (y < ay_min) ay_min = y;
        if (y > ay_max) ay_max = y;
      end
      acnt++;
    end
    e = pub;
    e.mask = sk ? 255 : 0;
    e.de = de; e.hs = hs; e.vs = vs;
    hist[n] = e;
  endtask

  task automatic check_outputs();
    exp_t e;
    e = '{default: 0};
    if (n >= 2) e = hist[n-2];
    check_eq("mask",       int'(bus.mask),       e.mask);
    check_eq("out_de",     int'(bus.out_de),     e.de);
    check_eq("out_hsync",  int'(bus.out_hsync),  e.hs);
    check_eq("out_vsync",  int'(bus.out_vsync),  e.vs);
    check_eq("bbox_valid", int'(bus.bbox_valid), e.valid);
    check_eq("x_min",      int'(bus.x_min),      e.xmin);
    check_eq("x_max",      int'(bus.x_max),      e.xmax);
    check_eq("y_min",      int'(bus.y_min),      e.ymin);
    check_eq("y_max",      int'(bus.y_max),      e.ymax);
    check_eq("skin_count", int'(bus.skin_count), e.cnt);
    check_eq("found",      int'(bus.found),      e.found);
  endtask

  task automatic check_pub(input string tag, input int xmn, input int xmx, input int ymn,
                           input int ymx, input int cnt, input int fnd, input int vld);
    check_eq({tag, ".x_min"},      int'(bus.x_min),      xmn);
    check_eq({tag, ".x_max"},      int'(bus.x_max),      xmx);
    check_eq({tag, ".y_min"},      int'(bus.y_min),      ymn);
    check_eq({tag, ".y_max"},      int'(bus.y_max),      ymx);
    check_eq({tag, ".skin_count"}, int'(bus.skin_count), cnt);
    check_eq({tag, ".found"},      int'(bus.found),      fnd);
    check_eq({tag, ".bbox_valid"}, int'(bus.bbox_valid), vld);
  endtask

  task automatic drive_random();
    bus.H = 8'($urandom);
    bus.S = 8'($urandom);
    bus.V = 8'($urandom);
    bus.in_hsync = 1'($urandom);
    bus.in_vsync = 1'($urandom);
    bus.in_de = 1'($urandom);
  endtask

  // One ce=1 sample; in gated mode it is followed by a ce=0 cycle carrying junk inputs
  task automatic cycle(input int h, input int s, input int v, input int hs,
                       input int vs, input int de, input int x, input int y);
    bus.H = 8'(h);
    bus.S = 8'(s);
    bus.V = 8'(v);
    bus.in_hsync = 1'(hs);
    bus.in_vsync = 1'(vs);
    bus.in_de = 1'(de);
    ce = 1'b1;
    model_push(h, s, v, hs, vs, de, x, y);
    @(posedge clk);
    #1;
    n++;
    check_outputs();
    if (gated) begin
      ce = 1'b0;
      drive_random();
      @(posedge clk);
      #1;
      check_outputs();
      ce = 1'b1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    n = 0;
    model_reset();
    check_outputs();
  endtask

  task automatic gen_pixel(input int mode, input int x, input int y,
                           output int h, output int s, output int v);
    int hb[4];
    int sb[4];
    int vb[4];
    hb = '{0, 25, 26, 255};
    sb = '{39, 40, 170, 171};
    vb = '{0, 59, 60, 255};
    case (mode)
      1: begin
        if ((x == 2 && y == 1) || (x == 5 && y == 3)) begin
          h = 10; s = 100; v = 100;
        end else begin
          h = 100; s = 100; v = 100;
        end
      end
      2: begin
        h = int'($urandom_range(26, 255)); s = int'($urandom_range(0, 255));
        v = int'($urandom_range(0, 255));
      end
      3: begin
        h = 10; s = 100; v = 100;
      end
      default: begin
        h = ($urandom_range(0, 3) == 0) ? hb[$urandom_range(0, 3)] : int'($urandom_range(0, 40));
        s = ($urandom_range(0, 3) == 0) ? sb[$urandom_range(0, 3)] : int'($urandom_range(30, 180));
        v = ($urandom_range(0, 3) == 0) ? vb[$urandom_range(0, 3)] : int'($urandom_range(40, 255));
      end
    endcase
  endtask

  task automatic line(input int mode, input int w, input int y);
    int h, s, v;
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    for (int x = 0; x < w; x++) begin
      gen_pixel(mode, x, y, h, s, v);
      cycle(h, s, v, 0, 0, 1, x, y);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lines(input int mode, input int w, input int hgt);
    for (int y = 0; y < hgt; y++) line(mode, w, y);
  endtask

  task automatic frame_begin();
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    ce = 1'b1;
    gated = 0;
    n = 0;
    model_reset();
    drive_random();
    do_reset(3);

    // Latency and threshold edges without any frame structure
    repeat (4) cycle(10, 100, 100, 0, 0, 1, 0, 0);
    cycle(26, 100, 100, 0, 0, 1, 0, 0);
    cycle(10, 170, 100, 0, 0, 1, 0, 0);
    cycle(10, 171, 100, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Skin before the first vsync rise must never be reported
    line(3, 4, 0);
    frame_begin();
    check_pub("first_rise", 0, 0, 0, 0, 0, 0, 0);
    lines(1, 8, 4);
    frame_begin();
    check_pub("bbox", 2, 5, 1, 3, 2, 1, 1);
    lines(2, 8, 4);
    frame_begin();
    check_pub("empty", 0, 0, 0, 0, 0, 0, 1);

    repeat (6) begin
      lines(0, int'($urandom_range(3, 12)), int'($urandom_range(1, 5)));
      frame_begin();
    end

    // ce toggling 1,0
    gated = 1;
    lines(1, 8, 4);
    frame_begin();
    check_pub("gated_bbox", 2, 5, 1, 3, 2, 1, 1);
    repeat (3) begin
      lines(0, int'($urandom_range(3, 10)), int'($urandom_range(1, 4)));
      frame_begin();
    end
    gated = 0;

    // Reset in the middle of a line after three skin pixels
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    for (int x = 0; x < 3; x++) cycle(10, 100, 100, 0, 0, 1, x, 0);
    do_reset(1);
    check_pub("reset", 0, 0, 0, 0, 0, 0, 0);
    check_eq("reset.mask", int'(bus.mask), 0);
    for (int x = 3; x < 6; x++) cycle(10, 100, 100, 0, 0, 1, x, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    frame_begin();
    check_pub("post_reset_rise", 0, 0, 0, 0, 0, 0, 0);
    lines(3, 4, 2);
    frame_begin();
    check_pub("post_reset_frame", 0, 3, 0, 1, 8, 1, 1);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
